half_adder: RTL and testbench



---
 rtl/half_adder_pkg.sv | 17 +
 rtl/half_adder_lane.sv | 12 +
 rtl/half_adder.sv | 72 +++++++
 tb/tb_half_adder.sv | 169 ++++++++++++++++
 4 files changed

// File: rtl/half_adder_pkg.sv
// Shared constants and helpers for the lane-parallel half adder.
package half_adder_pkg;

  localparam int DEFAULT_WIDTH = 1;
  localparam int DEFAULT_CNT_W = 16;
  localparam int MAX_WIDTH     = 64;
  localparam int POP_W         = $clog2(MAX_WIDTH + 1);

  // Callers zero-extend narrower words to MAX_WIDTH.
  function automatic logic [POP_W-1:0] popcount(input logic [MAX_WIDTH-1:0] w);
    logic [POP_W-1:0] n;
    n = '0;
    for (int i = 0; i < MAX_WIDTH; i++) n += POP_W'(w[i]);
    return n;
  endfunction

endpackage

// File: rtl/half_adder_lane.sv
// Single-bit combinational half-adder cell.
module half_adder_lane (
  input  logic a,
  input  logic b,
  output logic s,
  output logic c
);

  assign s = a ^ b;
  assign c = a & b;

endmodule

// File: rtl/half_adder.sv
// Registered lane-parallel half adder, 1-cycle latency, no backpressure.
// Optional carry-event counter enabled by HALF_ADDER_CARRY_COUNT_EN.
module half_adder
  import half_adder_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH,
  parameter int CNT_W = DEFAULT_CNT_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  output logic [WIDTH-1:0] S,
  output logic [WIDTH-1:0] C,
  output logic             C_any,
  output logic             out_valid
`ifdef HALF_ADDER_CARRY_COUNT_EN
  ,
  output logic [CNT_W-1:0] carry_count
`endif
);

  if (WIDTH < 1 || WIDTH > MAX_WIDTH || CNT_W < 1) begin : g_bad_param
    $error("half_adder: unsupported WIDTH/CNT_W");
  end

  logic [WIDTH-1:0] s_w, c_w;

  for (genvar i = 0; i < WIDTH; i++) begin : g_lane
    half_adder_lane u_lane (
      .a (A[i]),
      .b (B[i]),
      .s (s_w[i]),
      .c (c_w[i])
    );
  end

  // Data registers only load on valid, so unknown operands on idle cycles never leak in.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      S         <= '0;
      C         <= '0;
      C_any     <= 1'b0;
      out_valid <= 1'b0;
    end else begin
      out_valid <= in_valid;
      if (in_valid) begin
        S     <= s_w;
        C     <= c_w;
        C_any <= |c_w;
      end
    end
  end

`ifdef HALF_ADDER_CARRY_COUNT_EN
  // One spare bit above the wider of counter/popcount so the saturation compare cannot wrap.
  localparam int SUM_W = ((CNT_W > POP_W) ? CNT_W : POP_W) + 1;

  logic [SUM_W-1:0] cnt_sum;

  assign cnt_sum = SUM_W'(carry_count) + SUM_W'(popcount(MAX_WIDTH'(c_w)));

  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      carry_count <= '0;
    else if (in_valid)
      carry_count <= (cnt_sum > SUM_W'({CNT_W{1'b1}})) ? {CNT_W{1'b1}} : cnt_sum[CNT_W-1:0];
  end
`endif

endmodule

// File: tb/tb_half_adder.sv
// Randomized self-checking bench for half_adder with a per-cycle reference model.
module tb_half_adder;

  localparam int W  = 4;
  localparam int CW = 4;

  logic         clk = 1'b0;
  logic         rst = 1'b0;
  logic         in_valid = 1'b0;
  logic [W-1:0] A = '0, B = '0;
  logic [W-1:0] S, C;
  logic         C_any, out_valid;
`ifdef HALF_ADDER_CARRY_COUNT_EN
  logic [CW-1:0] carry_count;
`endif

  half_adder #(.WIDTH(W), .CNT_W(CW)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .A         (A),
    .B         (B),
    .S         (S),
    .C         (C),
    .C_any     (C_any),
    .out_valid (out_valid)
`ifdef HALF_ADDER_CARRY_COUNT_EN
    ,
    .carry_count (carry_count)
`endif
  );

  always #5 clk = ~clk;

  int checks = 0;
  int passes = 0;
  bit go = 1'b0;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got === exp) passes++;
    else $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
  endtask

  // Reference model: per-lane arithmetic sum a+b gives S as the low bit, C as the high bit.
  int m_s, m_c, m_any, m_ov, m_cnt;
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_s = 0; m_c = 0; m_any = 0; m_ov = 0; m_cnt = 0;
    end else begin
      m_ov = int'(in_valid);
      if (in_valid) begin
        int ncarry;
        ncarry = 0; m_s = 0; m_c = 0;
        for (int i = 0; i < W; i++) begin
          int tot;
          tot = int'(A[i]) + int'(B[i]);
          m_s += (tot % 2) * (1 << i);
          m_c += (tot / 2) * (1 << i);
          ncarry += tot / 2;
        end
        m_any = (m_c != 0) ? 1 : 0;
        m_cnt = (m_cnt + ncarry > (1 << CW) - 1) ? (1 << CW) - 1 : m_cnt + ncarry;
      end
    end
  end

  always @(negedge clk) begin
    if (go) begin
      chk("S",         32'(S),         32'(m_s));
      chk("C",         32'(C),         32'(m_c));
      chk("C_any",     32'(C_any),     32'(m_any));
      chk("out_valid", 32'(out_valid), 32'(m_ov));
`ifdef HALF_ADDER_CARRY_COUNT_EN
      chk("carry_count", 32'(carry_count), 32'(m_cnt));
`endif
    end
  end

  task automatic cycle();
    @(posedge clk); #2;
  endtask

  task automatic drive(input logic [W-1:0] a, input logic [W-1:0] b, input logic v);
    A = a; B = b; in_valid = v;
  endtask

  initial begin
    #1 rst = 1'b1;
    go = 1'b1;
    drive(4'hF, 4'hF, 1'b1);
    cycle(); cycle();
    chk("rst_S", 32'(S), 32'd0);
    chk("rst_C", 32'(C), 32'd0);
    chk("rst_ov", 32'(out_valid), 32'd0);
    rst = 1'b0;
    cycle();
    chk("first_S", 32'(S), 32'd0);
    chk("first_C", 32'(C), 32'hF);
    chk("first_ov", 32'(out_valid), 32'd1);

    // every lane truth-table row in one word
    drive(4'b1100, 4'b1010, 1'b1); cycle();
    chk("tt_S", 32'(S), 32'b0110);
    chk("tt_C", 32'(C), 32'b1000);
    chk("tt_any", 32'(C_any), 32'd1);
    drive(4'b0101, 4'b1010, 1'b1); cycle();
    chk("nc_S", 32'(S), 32'hF);
    chk("nc_C", 32'(C), 32'd0);
    chk("nc_any", 32'(C_any), 32'd0);

    // hold with idle and unknown operands
    drive(4'hF, 4'hF, 1'b1); cycle();
    drive(4'h0, 4'hF, 1'b0); cycle();
    chk("hold_S", 32'(S), 32'd0);
    chk("hold_C", 32'(C), 32'hF);
    chk("hold_ov", 32'(out_valid), 32'd0);
    drive('x, 'x, 1'b0); cycle();
    chk("x_C", 32'(C), 32'hF);
    chk("x_model", 32'(m_c), 32'hF);

    // async reset between edges
    drive(4'h3, 4'h3, 1'b1); cycle();
    rst = 1'b1; #1;
    chk("arst_C", 32'(C), 32'd0);
    chk("arst_ov", 32'(out_valid), 32'd0);
    cycle(); rst = 1'b0;

`ifdef HALF_ADDER_CARRY_COUNT_EN
    begin
      int exp_cnt [5] = '{4, 8, 12, 15, 15};
      for (int k = 0; k < 5; k++) begin
        drive(4'hF, 4'hF, 1'b1); cycle();
        chk("cnt_sat", 32'(carry_count), 32'(exp_cnt[k]));
      end
      rst = 1'b1; cycle(); rst = 1'b0;
      chk("cnt_rst", 32'(carry_count), 32'd0);
    end
`endif

    // randomized traffic with occasional mid-stream resets
    for (int n = 0; n < 500; n++) begin
      drive(W'($urandom), W'($urandom), 1'($urandom_range(0, 3) != 0));
      if ($urandom_range(0, 49) == 0) begin
        rst = 1'b1; #1;
        chk("rnd_arst_S", 32'(S), 32'd0);
        chk("rnd_arst_ov", 32'(out_valid), 32'd0);
        cycle();
        rst = 1'b0;
      end else begin
        cycle();
      end
    end

    in_valid = 1'b0;
    cycle();
    @(negedge clk); #1;
    go = 1'b0;
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: bench did not finish, got %0d/%0d", passes, checks);
    $fatal(1);
  end

endmodule
